seg_scan_decoder: RTL

- Receive-side counterpart of the digit-to-segment encoder.
- Samples a multiplexed seven-segment bus (segment byte plus one-hot digit select) and waits for each digit's pattern to be stable.
- Decodes each stable pattern back to a 4-bit BCD value, assembles a full multi-digit frame, and reports it with a one-cycle valid pulse.
- Used as display readback/self-check in the stabilization board and as a checker in benches.

---
 rtl/seg_pkg.sv | 29 ++
 rtl/seg_pattern_decode.sv | 29 ++
 rtl/seg_scan_decoder.sv | 117 +++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment constants for the display encoder and scan decoder.
// Segment patterns are active-high, bit0=a .. bit6=g, bit7=dp.
package seg_pkg;

    // Segment bit positions on the 8-bit bus
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Digit glyphs, segments a..g
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7C;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h67;

    localparam logic [3:0] BCD_INVALID = 4'hF;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment glyph to BCD decoder.
// Ports: i_pattern (segments a..g), o_bcd (0..9 or 4'hF), o_valid.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_bcd,
    output logic       o_valid
);

    always_comb begin
        o_bcd   = BCD_INVALID;
        o_valid = 1'b1;
        unique case (i_pattern)
            SEG_0:   o_bcd = 4'd0;
            SEG_1:   o_bcd = 4'd1;
            SEG_2:   o_bcd = 4'd2;
            SEG_3:   o_bcd = 4'd3;
            SEG_4:   o_bcd = 4'd4;
            SEG_5:   o_bcd = 4'd5;
            SEG_6:   o_bcd = 4'd6;
            SEG_7:   o_bcd = 4'd7;
            SEG_8:   o_bcd = 4'd8;
            SEG_9:   o_bcd = 4'd9;
            default: o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Multiplexed seven-segment bus readback: debounce, decode, assemble frame.
// Ports: clk, rst (sync, high), sevenSeg, digitSel -> frameDigits/Valid/Error.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              sevenSeg,
    input  logic [NUM_DIGITS-1:0]   digitSel,
    output logic [4*NUM_DIGITS-1:0] frameDigits,
    output logic                    frameValid,
    output logic                    frameError
);

    localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [7:0]              r_prev_seg;
    logic [NUM_DIGITS-1:0]   r_prev_sel;
    logic [CNT_W-1:0]        r_cnt;
    logic [NUM_DIGITS-1:0]   r_mask;
    logic [NUM_DIGITS-1:0]   r_err;
    logic [4*NUM_DIGITS-1:0] r_slot;
    logic [4*NUM_DIGITS-1:0] r_frame_digits;
    logic                    r_frame_valid;
    logic                    r_frame_error;

    logic                    w_onehot;
    logic                    w_same;
    logic                    w_capture;
    logic                    w_complete;
    logic [3:0]              w_bcd;
    logic                    w_valid;
    logic [NUM_DIGITS-1:0]   w_mask_next;
    logic [NUM_DIGITS-1:0]   w_err_next;
    logic [4*NUM_DIGITS-1:0] w_slot_next;

    // On a capture edge the input equals the previous sample,
    // so decoding the registered copy is the same glyph.
    seg_pattern_decode u_dec (
        .i_pattern (r_prev_seg[SEG_G:SEG_A]),
        .o_bcd     (w_bcd),
        .o_valid   (w_valid)
    );

    assign w_onehot  = $onehot(digitSel);
    assign w_same    = ({sevenSeg, digitSel} == {r_prev_seg, r_prev_sel});
    assign w_capture = w_onehot && w_same && (r_cnt == CNT_ARM);

    // digitSel is one-hot whenever these are consumed
    assign w_mask_next = r_mask | digitSel;
    assign w_err_next  = (r_err & ~digitSel)
                       | ({NUM_DIGITS{~w_valid}} & digitSel);
    assign w_complete  = w_capture && (&w_mask_next);

    always_comb begin
        w_slot_next = r_slot;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digitSel[i]) begin
                w_slot_next[4*i +: 4] = w_bcd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_seg     <= '0;
            r_prev_sel     <= '0;
            r_cnt          <= '0;
            r_mask         <= '0;
            r_err          <= '0;
            r_slot         <= '0;
            r_frame_digits <= '0;
            r_frame_valid  <= 1'b0;
            r_frame_error  <= 1'b0;
        end else begin
            r_prev_seg    <= sevenSeg;
            r_prev_sel    <= digitSel;
            r_frame_valid <= 1'b0;

            // Saturating run length; blanking/ghosting resets it
            if (!w_onehot) begin
                r_cnt <= '0;
            end else if (w_same) begin
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end else begin
                r_cnt <= CNT_ONE;
            end

            if (w_capture) begin
                r_slot <= w_slot_next;
                if (w_complete) begin
                    r_frame_digits <= w_slot_next;
                    r_frame_error  <= |w_err_next;
                    r_frame_valid  <= 1'b1;
                    r_mask         <= '0;
                    r_err          <= '0;
                end else begin
                    r_mask <= w_mask_next;
                    r_err  <= w_err_next;
                end
            end
        end
    end

    assign frameDigits = r_frame_digits;
    assign frameValid  = r_frame_valid;
    assign frameError  = r_frame_error;

endmodule
